// File: rtl/out_drain_ctrl_pkg.sv
// out_drain_pkg: shared constants and types for the output-buffer drain
// scheduler (out_drain_ctrl) and its arbiter (rr_arb3).
//   NPORT        number of output RAMs
//   ADDR_W       RAM address width, DEPTH = 2**ADDR_W
//   DATA_W       RAM word width
//   drain_state_e  FSM encoding IDLE/READ/LOAD/HOLD
//   port_idx_t   2-bit RAM index
package out_drain_pkg;

    localparam int NPORT  = 3;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LOAD = 2'd2,
        HOLD = 2'd3
    } drain_state_e;

    typedef logic [1:0] port_idx_t;

    // Next port index in 0 -> 1 -> 2 -> 0 order.
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/out_drain_ctrl_if.sv
// out_drain_ctrl_if: drained-word stream toward the host read logic.
//   out_data   drained RAM word
//   out_port   source RAM index (0..2)
//   out_valid  out_data/out_port valid
//   out_ready  consumer accepts the word
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready low, out_data and out_port hold
// steady and out_valid stays high; out_valid never depends on out_ready.
// Modports: master (producer, out_drain_ctrl), slave (consumer).
interface out_drain_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_port;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_port,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_port,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/out_drain_ctrl_rr_arb3.sv
// rr_arb3: combinational 3-way arbiter for the drain scheduler.
//   request     per-RAM non-empty flags
//   last_grant  index granted last time
//   grant       chosen index (valid when any_req)
//   any_req     at least one request
// Build option: OUT_DRAIN_STRICT_PRIO_EN selects fixed priority 0 > 1 > 2
// and ignores last_grant; otherwise round-robin starting after last_grant.
module rr_arb3
    import out_drain_pkg::*;
(
    input  logic [2:0] request,
    input  port_idx_t  last_grant,
    output port_idx_t  grant,
    output logic       any_req
);

`ifdef OUT_DRAIN_STRICT_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        grant   = 2'd0;
        any_req = |request;
        if (request[0])      grant = 2'd0;
        else if (request[1]) grant = 2'd1;
        else if (request[2]) grant = 2'd2;
    end
`else
    port_idx_t p1;
    port_idx_t p2;

    always_comb begin
        p1      = next_port(last_grant);
        p2      = next_port(p1);
        grant   = 2'd0;
        any_req = |request;
        // Search order: last_grant+1, last_grant+2, then last_grant itself.
        if (request[p1])              grant = p1;
        else if (request[p2])         grant = p2;
        else if (request[last_grant]) grant = last_grant;
    end
`endif

endmodule

// File: rtl/out_drain_ctrl.sv
// out_drain_ctrl: drain scheduler for the three output RAMs.
// Owns per-RAM write/read pointers, arbitrates among non-empty RAMs and
// sequences the one-cycle-latency RAM read onto a valid/ready stream.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   wr_strobe[i]       engine i writes one word into RAM i
//   ram_wraddress/wren per-RAM write port (combinational from pointers)
//   ram_rdaddress/rden per-RAM read port, rden one-hot or zero
//   ram_q              per-RAM read data, valid one cycle after rden
//   drain_en           permits new grants
//   out_s              drained-word stream (master modport)
//   fill               per-RAM occupancy 0..DEPTH
//   overflow           sticky dropped-write flags
//   state_dbg          current FSM state
// Build option: OUT_DRAIN_STRICT_PRIO_EN (see rr_arb3).
module out_drain_ctrl
    import out_drain_pkg::NPORT;
    import out_drain_pkg::port_idx_t;
    import out_drain_pkg::IDLE;
    import out_drain_pkg::READ;
    import out_drain_pkg::LOAD;
    import out_drain_pkg::HOLD;
#(
    parameter int ADDR_W = out_drain_pkg::ADDR_W,
    parameter int DATA_W = out_drain_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NPORT-1:0]              wr_strobe,
    output logic [NPORT*ADDR_W-1:0]       ram_wraddress,
    output logic [NPORT-1:0]              ram_wren,
    output logic [NPORT*ADDR_W-1:0]       ram_rdaddress,
    output logic [NPORT-1:0]              ram_rden,
    input  logic [NPORT*DATA_W-1:0]       ram_q,
    input  logic                          drain_en,
    out_drain_ctrl_if.master              out_s,
    output logic [NPORT*(ADDR_W+1)-1:0]   fill,
    output logic [NPORT-1:0]              overflow,
    output logic [1:0]                    state_dbg
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_READ = 2'(READ);
    localparam logic [1:0] ST_LOAD = 2'(LOAD);
    localparam logic [1:0] ST_HOLD = 2'(HOLD);

    // Pointers carry one extra wrap bit so full and empty are distinct.
    logic [PTR_W-1:0]  wr_ptr [NPORT];
    logic [PTR_W-1:0]  rd_ptr [NPORT];
    logic [PTR_W-1:0]  occ    [NPORT];
    logic [NPORT-1:0]  full;
    logic [NPORT-1:0]  nonempty;

    logic [1:0]        state;
    port_idx_t         g;
    port_idx_t         last_grant;
    port_idx_t         arb_grant;
    logic              any_req;
    logic [DATA_W-1:0] q_sel;

    assign state_dbg = state;

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            occ[i]      = wr_ptr[i] - rd_ptr[i];
            full[i]     = (occ[i] == DEPTH_P);
            nonempty[i] = (occ[i] != '0);
            ram_wren[i] = wr_strobe[i] && !full[i];
            ram_rden[i] = (state == ST_READ) && (g == port_idx_t'(i));
            ram_wraddress[i*ADDR_W +: ADDR_W] = wr_ptr[i][ADDR_W-1:0];
            ram_rdaddress[i*ADDR_W +: ADDR_W] = rd_ptr[i][ADDR_W-1:0];
            fill[i*PTR_W +: PTR_W]            = occ[i];
        end
    end

    always_comb begin
        q_sel = ram_q[DATA_W-1:0];
        if (g == 2'd1) q_sel = ram_q[DATA_W +: DATA_W];
        if (g == 2'd2) q_sel = ram_q[2*DATA_W +: DATA_W];
    end

    rr_arb3 u_arb (
        .request    (nonempty),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any_req    (any_req)
    );

    // Pointer and overflow tracking. A write against a full RAM is dropped
    // even if a read retires a word on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPORT; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (ram_wren[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (ram_rden[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (wr_strobe[i] && full[i])
                    overflow[i] <= 1'b1;
            end
        end
    end

    // Drain sequence: IDLE grants, READ issues rden, LOAD captures ram_q,
    // HOLD presents the word until the consumer takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            g               <= 2'd0;
            last_grant      <= 2'd2;
            out_s.out_data  <= '0;
            out_s.out_port  <= 2'd0;
            out_s.out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (drain_en && any_req) begin
                        g          <= arb_grant;
                        last_grant <= arb_grant;
                        state      <= ST_READ;
                    end
                end
                ST_READ: state <= ST_LOAD;
                ST_LOAD: begin
                    out_s.out_data  <= q_sel;
                    out_s.out_port  <= g;
                    out_s.out_valid <= 1'b1;
                    state           <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_s.out_valid && out_s.out_ready) begin
                        out_s.out_valid <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_drain_ctrl.sv
module tb_out_drain_ctrl;
    import out_drain_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int PW = AW + 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [2:0]      wr_strobe;
    logic [3*AW-1:0] ram_wraddress;
    logic [2:0]      ram_wren;
    logic [3*AW-1:0] ram_rdaddress;
    logic [2:0]      ram_rden;
    logic [3*DW-1:0] ram_q;
    logic            drain_en;
    logic [3*PW-1:0] fill;
    logic [2:0]      overflow;
    logic [1:0]      state_dbg;

    out_drain_ctrl_if #(.DATA_W(DW)) s_if ();

    out_drain_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_strobe     (wr_strobe),
        .ram_wraddress (ram_wraddress),
        .ram_wren      (ram_wren),
        .ram_rdaddress (ram_rdaddress),
        .ram_rden      (ram_rden),
        .ram_q         (ram_q),
        .drain_en      (drain_en),
        .out_s         (s_if),
        .fill          (fill),
        .overflow      (overflow),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read (one-cycle latency).
    logic [DW-1:0] mem [3][4096];
    logic [DW-1:0] q_r [3];
    logic [DW-1:0] wdata [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ram_wren[i]) mem[i][ram_wraddress[i*AW +: AW]] <= wdata[i];
            if (ram_rden[i]) q_r[i] <= mem[i][ram_rdaddress[i*AW +: AW]];
        end
    end
    assign ram_q = {q_r[2], q_r[1], q_r[0]};

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW+1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] fill_of(input int i);
        return fill[i*PW +: PW];
    endfunction

    function automatic logic [AW-1:0] rdaddr_of(input int i);
        return ram_rdaddress[i*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] wraddr_of(input int i);
        return ram_wraddress[i*AW +: AW];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_strobe = '0;
        drain_en  = 1'b0;
        s_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) wdata[i] = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!s_if.out_valid && n < 20) begin
            step();
            n++;
        end
        check({name, " valid timeout"}, 64'(s_if.out_valid), 64'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]    wr;
        logic [DW-1:0] wd;
        logic          de;
        logic          rdy;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [2:0]    exp_rden;
        logic [AW-1:0] exp_rdaddr;
        logic [PW-1:0] exp_fill;
        logic [2:0]    exp_wren;
        logic [AW-1:0] exp_wraddr;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'b001, 32'hA0, 1'b1, 1'b1, 1'b0, 32'h0,  3'b000, 12'd0, 13'd0, 3'b001, 12'd0};
        vecs[1]  = '{3'b001, 32'hA1, 1'b1, 1'b1, 1'b0, 32'h0,  3'b000, 12'd0, 13'd1, 3'b001, 12'd1};
        vecs[2]  = '{3'b001, 32'hA2, 1'b1, 1'b1, 1'b0, 32'h0,  3'b001, 12'd0, 13'd2, 3'b001, 12'd2};
        vecs[3]  = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  3'b000, 12'd1, 13'd2, 3'b000, 12'd3};
        vecs[4]  = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA0, 3'b000, 12'd1, 13'd2, 3'b000, 12'd3};
        vecs[5]  = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  3'b000, 12'd1, 13'd2, 3'b000, 12'd3};
        vecs[6]  = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  3'b001, 12'd1, 13'd2, 3'b000, 12'd3};
        vecs[7]  = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  3'b000, 12'd2, 13'd1, 3'b000, 12'd3};
        vecs[8]  = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA1, 3'b000, 12'd2, 13'd1, 3'b000, 12'd3};
        vecs[9]  = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  3'b000, 12'd2, 13'd1, 3'b000, 12'd3};
        vecs[10] = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  3'b001, 12'd2, 13'd1, 3'b000, 12'd3};
        vecs[11] = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  3'b000, 12'd3, 13'd0, 3'b000, 12'd3};
        vecs[12] = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA2, 3'b000, 12'd3, 13'd0, 3'b000, 12'd3};
        vecs[13] = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  3'b000, 12'd3, 13'd0, 3'b000, 12'd3};
        vecs[14] = '{3'b000, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  3'b000, 12'd3, 13'd0, 3'b000, 12'd3};

        // ---- reset state ----
        do_reset();
        check("rst out_valid", 64'(s_if.out_valid), 64'd0);
        check("rst out_data",  64'(s_if.out_data),  64'd0);
        check("rst out_port",  64'(s_if.out_port),  64'd0);
        check("rst ram_rden",  64'(ram_rden),       64'd0);
        check("rst ram_wren",  64'(ram_wren),       64'd0);
        check("rst fill",      64'(fill),           64'd0);
        check("rst overflow",  64'(overflow),       64'd0);
        check("rst state",     64'(state_dbg),      64'(IDLE));

        // ---- table: port 0 writes three words and drains them ----
        for (int k = 0; k < 15; k++) begin
            wr_strobe      = vecs[k].wr;
            wdata[0]       = vecs[k].wd;
            drain_en       = vecs[k].de;
            s_if.out_ready = vecs[k].rdy;
            #1;
            check($sformatf("vec%0d out_valid", k), 64'(s_if.out_valid), 64'(vecs[k].exp_valid));
            if (vecs[k].exp_valid) begin
                check($sformatf("vec%0d out_data", k), 64'(s_if.out_data), 64'(vecs[k].exp_data));
                check($sformatf("vec%0d out_port", k), 64'(s_if.out_port), 64'd0);
            end
            check($sformatf("vec%0d ram_rden", k),   64'(ram_rden),     64'(vecs[k].exp_rden));
            check($sformatf("vec%0d rdaddress0", k), 64'(rdaddr_of(0)), 64'(vecs[k].exp_rdaddr));
            check($sformatf("vec%0d fill0", k),      64'(fill_of(0)),   64'(vecs[k].exp_fill));
            check($sformatf("vec%0d ram_wren", k),   64'(ram_wren),     64'(vecs[k].exp_wren));
            check($sformatf("vec%0d wraddress0", k), 64'(wraddr_of(0)), 64'(vecs[k].exp_wraddr));
            step();
        end
        wr_strobe = '0;

        // ---- two words per RAM, then drain: arbitration order ----
        do_reset();
        for (int j = 0; j < 2; j++) begin
            wr_strobe = 3'b111;
            for (int i = 0; i < 3; i++) wdata[i] = DW'(32'hB0 + 16 * i + j);
            step();
        end
        wr_strobe = '0;
`ifdef OUT_DRAIN_STRICT_PRIO_EN
        exp_q.push_back({2'd0, 32'hB0}); exp_q.push_back({2'd0, 32'hB1});
        exp_q.push_back({2'd1, 32'hC0}); exp_q.push_back({2'd1, 32'hC1});
        exp_q.push_back({2'd2, 32'hD0}); exp_q.push_back({2'd2, 32'hD1});
`else
        exp_q.push_back({2'd0, 32'hB0}); exp_q.push_back({2'd1, 32'hC0});
        exp_q.push_back({2'd2, 32'hD0}); exp_q.push_back({2'd0, 32'hB1});
        exp_q.push_back({2'd1, 32'hC1}); exp_q.push_back({2'd2, 32'hD1});
`endif
        drain_en = 1'b1;
        s_if.out_ready = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            if (s_if.out_valid && s_if.out_ready) begin
                logic [DW+1:0] e;
                e = exp_q.pop_front();
                check("arb port", 64'(s_if.out_port), 64'(e[DW+1:DW]));
                check("arb data", 64'(s_if.out_data), 64'(e[DW-1:0]));
            end
            step();
        end
        check("arb words left", 64'(exp_q.size()), 64'd0);
        check("arb fill drained", 64'(fill), 64'd0);

        // ---- backpressure: HOLD for 10 cycles ----
        s_if.out_ready = 1'b0;
        wr_strobe = 3'b100;
        wdata[2]  = 32'hC5;
        step();
        wr_strobe = '0;
        wait_valid("hold");
        for (int c = 0; c < 10; c++) begin
            check("hold out_valid", 64'(s_if.out_valid), 64'd1);
            check("hold out_data",  64'(s_if.out_data),  64'hC5);
            check("hold out_port",  64'(s_if.out_port),  64'd2);
            check("hold ram_rden",  64'(ram_rden),       64'd0);
            step();
        end
        s_if.out_ready = 1'b1;
        step();
        check("hold release valid", 64'(s_if.out_valid), 64'd0);
        drain_en = 1'b0;

        // ---- fill port 1 to full, overflow, then wrap ----
        do_reset();
        s_if.out_ready = 1'b1;
        for (int j = 0; j < 4096; j++) begin
            wr_strobe = 3'b010;
            wdata[1]  = 32'h1000_0000 + DW'(j);
            step();
        end
        check("full fill1", 64'(fill_of(1)), 64'd4096);
        check("full overflow pre", 64'(overflow), 64'd0);
        wdata[1] = 32'h1000_1000;
        #1;
        check("full wren dropped", 64'(ram_wren), 64'd0);
        step();
        wr_strobe = '0;
        check("full overflow", 64'(overflow), 64'b010);
        check("full fill1 after drop", 64'(fill_of(1)), 64'd4096);
        drain_en = 1'b1;
        step();
        drain_en = 1'b0;
        wait_valid("wrap");
        check("wrap out_data", 64'(s_if.out_data), 64'h1000_0000);
        check("wrap out_port", 64'(s_if.out_port), 64'd1);
        step();
        check("wrap fill1 after read", 64'(fill_of(1)), 64'd4095);
        check("wrap rdaddress1", 64'(rdaddr_of(1)), 64'd1);
        wr_strobe = 3'b010;
        wdata[1]  = 32'hDEAD;
        #1;
        check("wrap wren", 64'(ram_wren), 64'b010);
        check("wrap wraddress1", 64'(wraddr_of(1)), 64'd0);
        step();
        wr_strobe = '0;
        check("wrap fill1", 64'(fill_of(1)), 64'd4096);

        // ---- reset during HOLD ----
        drain_en = 1'b1;
        s_if.out_ready = 1'b0;
        wait_valid("rst hold");
        check("rst hold port", 64'(s_if.out_port), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst valid",    64'(s_if.out_valid), 64'd0);
        check("async rst fill",     64'(fill),           64'd0);
        check("async rst overflow", 64'(overflow),       64'd0);
        check("async rst state",    64'(state_dbg),      64'(IDLE));
        drain_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wr_strobe = 3'b111;
        wdata[0] = 32'hE0; wdata[1] = 32'hE1; wdata[2] = 32'hE2;
        step();
        wr_strobe = '0;
        drain_en = 1'b1;
        s_if.out_ready = 1'b1;
        wait_valid("post rst");
        check("post rst port", 64'(s_if.out_port), 64'd0);
        check("post rst data", 64'(s_if.out_data), 64'hE0);

        // ---- drain_en dropped during READ ----
        do_reset();
        for (int j = 0; j < 2; j++) begin
            wr_strobe = 3'b001;
            wdata[0]  = DW'(32'hF0 + j);
            step();
        end
        wr_strobe = '0;
        s_if.out_ready = 1'b1;
        drain_en = 1'b1;
        step();
        drain_en = 1'b0;
        #1;
        check("de drop state", 64'(state_dbg), 64'(READ));
        check("de drop rden",  64'(ram_rden),  64'b001);
        wait_valid("de drop");
        check("de drop data", 64'(s_if.out_data), 64'hF0);
        step();
        for (int c = 0; c < 8; c++) begin
            check("de off rden",  64'(ram_rden),       64'd0);
            check("de off valid", 64'(s_if.out_valid), 64'd0);
            step();
        end
        check("de off fill0", 64'(fill_of(0)), 64'd1);
        drain_en = 1'b1;
        wait_valid("de resume");
        check("de resume data", 64'(s_if.out_data), 64'hF1);
        check("de resume port", 64'(s_if.out_port), 64'd0);

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
